// File: rtl/i2s_pkg.sv
// Shared widths, frame sizing helper and the stereo sample type for the I2S output path.
package i2s_pkg;

    localparam int DEFAULT_DATA_W = 24;
    localparam int DEFAULT_SLOT_W = 32;

    function automatic int frame_bits(input int slot_w);
        return 2 * slot_w;
    endfunction

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] left;
        logic [DEFAULT_DATA_W-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider: toggles bclk every BCLK_DIV clk cycles and flags the edge being produced.
module i2s_clk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);

    localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    assign wrap      = (cnt_q == CW'(BCLK_DIV - 1));
    // Strobes are combinational so the top acts on the same edge that toggles bclk.
    assign bclk_rise = wrap && !bclk_q;
    assign bclk_fall = wrap && bclk_q;
    assign bclk      = bclk_q;

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        bclk_d = bclk_q ^ wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: stages one stereo frame via valid/ready and shifts it out MSB first,
// one bit per BCLK fall, reloading the shift register at every frame boundary.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int SLOT_W   = DEFAULT_SLOT_W,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] left_data,
    input  logic [DATA_W-1:0] right_data,
    input  logic              valid,
    output logic              ready,
    output logic              bclk,
    output logic              lrck,
    output logic              sdata,
    output logic              underrun
);

    localparam int FRAME_W = frame_bits(SLOT_W);
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int PAD     = SLOT_W - DATA_W - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } stage_t;

    logic               bclk_rise, bclk_fall;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    stage_t             stage_q, stage_d;
    logic               full_q, full_d;
    logic               ready_q;
    logic               lrck_q, lrck_d;
    logic               sdata_q, sdata_d;
    logic               underrun_q, underrun_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [SLOT_W-1:0]  slot_l, slot_r;
    logic [FRAME_W-1:0] frame;
    logic               accept, boundary;

    i2s_clk_gen #(.BCLK_DIV(BCLK_DIV)) u_clk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .bclk     (bclk),
        .bclk_rise(bclk_rise),
        .bclk_fall(bclk_fall)
    );

    assign accept   = valid && ready_q;
    assign boundary = bclk_fall && (bit_cnt_q == LAST);

    always_comb begin
        // Each slot: leading zero (one-bit delay), sample, zero padding.
        slot_l     = SLOT_W'(stage_q.left) << PAD;
        slot_r     = SLOT_W'(stage_q.right) << PAD;
        frame      = full_q ? {slot_l, slot_r} : '0;
        bit_cnt_d  = bit_cnt_q;
        lrck_d     = lrck_q;
        sdata_d    = sdata_q;
        shreg_d    = shreg_q;
        stage_d    = stage_q;
        full_d     = full_q;
        underrun_d = 1'b0;
        if (bclk_fall) begin
            bit_cnt_d = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + 1'b1;
            lrck_d    = (bit_cnt_d >= CNT_W'(SLOT_W));
            if (boundary) begin
                sdata_d    = frame[FRAME_W-1];
                shreg_d    = {frame[FRAME_W-2:0], 1'b0};
                underrun_d = !full_q;
                full_d     = 1'b0;
            end else begin
                sdata_d = shreg_q[FRAME_W-1];
                shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            end
        end
        // Accept only happens when staging is empty, so it never clobbers a frame the boundary needs.
        if (accept) begin
            stage_d = '{left: left_data, right: right_data};
            full_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q  <= LAST;
            stage_q    <= '0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            lrck_q     <= 1'b1;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            shreg_q    <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            stage_q    <= stage_d;
            full_q     <= full_d;
            ready_q    <= !full_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            shreg_q    <= shreg_d;
        end
    end

    assign ready    = ready_q;
    assign lrck     = lrck_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

    a_one_edge: assert property (@(posedge clk) disable iff (!reset_n) !(bclk_rise && bclk_fall));

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serializes filtered stereo samples onto an I2S DAC link, generating BCLK and LRCK from the system clock. It accepts one stereo frame at a time from the filter output path through a valid/ready handshake and holds it in a staging register. The staged frame moves into the shift register at each frame boundary. It is the output end of the sample stream the FIFO/accumulator filter chain produces.

## Interface
- DATA_W, 24, sample width, two's complement (matches filter datapath)
- SLOT_W, 32, BCLK periods per channel slot; must be ≥ DATA_W+1
- BCLK_DIV, 4, clk cycles per BCLK half-period; ≥ 2
- clk  input  1  system clock; all logic on posedge
- reset_n  input  1  asynchronous, active-low reset
- left_data  input  DATA_W  left sample, valid with valid
- right_data  input  DATA_W  right sample, valid with valid
- valid  input  1  frame offered
- ready  output  1  staging register empty; transfer on posedge when valid && ready
- bclk  output  1  bit clock, registered
- lrck  output  1  word select: 0 = left slot, 1 = right slot
- sdata  output  1  serial data, MSB first, changes on BCLK fall
- underrun  output  1  one-clk pulse when a frame boundary finds staging empty

## Operation
- Reset values, applied asynchronously: bclk=0, lrck=1, sdata=0, ready=1, underrun=0. Staging is cleared and marked empty. The divider counter is 0, bit_cnt is 2*SLOT_W-1, and the shift register is all zeros.
- Divider: counter runs 0..BCLK_DIV-1. At BCLK_DIV-1, bclk toggles and the counter returns to 0. A rise event is the toggle with bclk=0; a fall event is the toggle with bclk=1.
- Fall event: bit_cnt increments modulo 2*SLOT_W. lrck is set to 0 for new bit_cnt < SLOT_W, else 1. sdata is set to the shift register MSB, then the shift register shifts left with zero fill.
- Frame boundary: the fall event on which bit_cnt wraps to 0. The shift register loads {1'b0, left, (SLOT_W-DATA_W-1) zeros, 1'b0, right, (SLOT_W-DATA_W-1) zeros} from staging, and sdata takes its MSB (0). Staging is marked empty.
- Standard I2S one-bit delay: MSB appears on the second BCLK fall after the LRCK transition.
- Empty staging at boundary: the shift register loads all zeros and underrun pulses high for exactly that clk cycle.
- Handshake:
  - ready is registered and equals NOT staging_full.
  - On valid && ready, staging captures left_data/right_data and ready drops the next cycle.
  - ready returns high the cycle after a boundary consumes staging.
  - valid with ready low is ignored. The source holds its data.
- Simultaneous transfer and boundary with staging empty: the boundary loads zeros and pulses underrun. The incoming frame lands in staging and goes out at the next boundary.
- No arithmetic on samples; bits are passed verbatim.

## Timing
- BCLK period is 2*BCLK_DIV clk cycles. The frame period is 2*SLOT_W*2*BCLK_DIV clk cycles (512 at defaults).
- After reset release: first rise at clk edge BCLK_DIV, first fall and first frame boundary at edge 2*BCLK_DIV.
- Latency from accept to first data bit: the next frame boundary plus one BCLK period.
- sdata and lrck change only on fall events, so they are stable across each BCLK rise, where the DAC samples.
- Reset assertion mid-frame aborts the frame immediately and discards staging. Transmission restarts with a fresh frame boundary 2*BCLK_DIV cycles after release.

## Structure
- Package i2s_pkg:
  - localparams DEFAULT_DATA_W=24, DEFAULT_SLOT_W=32
  - function frame_bits(slot_w) returning 2*slot_w
  - typedef stereo_sample_t struct {left, right}, DATA_W each
- Sub-module i2s_clk_gen: divider producing bclk plus single-cycle bclk_rise/bclk_fall strobes.
- The top holds bit_cnt, staging, the shift register and the handshake.

## Test plan
- Reset: reset_n low → bclk=0, lrck=1, sdata=0, ready=1, underrun=0. After release → bclk rises at clk 4 and falls at clk 8, where lrck goes 0.
- Single frame, left=24'h800001, right=24'h7FFFFE, one valid pulse. Sampling sdata on BCLK rises from the lrck fall:
  - left slot: 0, 1, 22×0, 1, then 7×0
  - right slot (lrck=1): 0, 0, 22×1, 0, then 7×0
- Idle source: no valid for 3 frames → all-zero sdata, underrun pulses at clk 8, 520, 1032.
- Backpressure: valid held high with frame A, then frame B:
  - A accepted, ready low until the next boundary
  - B accepted the cycle after ready returns
  - A and B transmitted on consecutive frames, no underrun after the first
- Transfer on boundary cycle with staging empty → zero frame plus underrun. The offered frame appears on the following frame intact.
- Reset mid-frame: reset_n low at left bit 10 → outputs return to reset values in the same cycle and staging is lost. Restart behaves like the reset scenario.
